// File: rtl/drop_actuator_ctrl.sv
// drop_actuator_ctrl: turns the baggage_drop decision into a confirmed, timed
// hatch-open command, supervises hatch closure and latches a close-timeout fault.
// Build option: define DROP_COUNTER_EN to enable the saturating drop_count;
// when it is undefined, drop_count is tied to zero.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | waiting for an armed request
// S_CONFIRM   | request must persist CONFIRM_CYC cycles (glitch filter)
// S_OPEN      | hatch_open_cmd high for OPEN_CYC cycles, abort closes early
// S_CLOSING   | waiting for hatch_closed, bounded by CLOSE_TIMEOUT
// S_COOLDOWN  | requests ignored for COOLDOWN_CYC cycles
// S_FAULT     | hatch failed to close; left only through rst_n
module drop_actuator_ctrl #(
  parameter int CONFIRM_CYC   = 4,
  parameter int OPEN_CYC      = 16,
  parameter int CLOSE_TIMEOUT = 32,
  parameter int COOLDOWN_CYC  = 8,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             drop_activated,
  input  logic             drop_en,
  input  logic             abort,
  input  logic             hatch_closed,
  output logic             hatch_open_cmd,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [CNT_W-1:0] drop_count
);

  localparam int MAX_CO  = (CONFIRM_CYC > OPEN_CYC) ? CONFIRM_CYC : OPEN_CYC;
  localparam int MAX_CC  = (CLOSE_TIMEOUT > COOLDOWN_CYC) ? CLOSE_TIMEOUT : COOLDOWN_CYC;
  localparam int MAX_ALL = (MAX_CO > MAX_CC) ? MAX_CO : MAX_CC;
  localparam int TW      = (MAX_ALL > 1) ? $clog2(MAX_ALL) : 1;

  localparam logic [TW-1:0] CONFIRM_LAST = TW'(CONFIRM_CYC - 1);
  localparam logic [TW-1:0] OPEN_LAST    = TW'(OPEN_CYC - 1);
  localparam logic [TW-1:0] CLOSE_LAST   = TW'(CLOSE_TIMEOUT - 1);
  localparam logic [TW-1:0] COOL_LAST    = TW'(COOLDOWN_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONFIRM,
    S_OPEN,
    S_CLOSING,
    S_COOLDOWN,
    S_FAULT
  } state_t;

  state_t        state;
  logic [TW-1:0] cnt;
  logic          armed;
  logic          req;

  assign req = drop_activated & drop_en & ~abort;

  // Sequencer: state, shared cycle counter, re-arm flag and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      cnt            <= '0;
      armed          <= 1'b1;
      hatch_open_cmd <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      fault          <= 1'b0;
    end else begin
      done <= 1'b0;
      // Any low sample of the decision re-arms; OPEN entry below clears it again.
      if (!drop_activated) armed <= 1'b1;
      case (state)
        S_IDLE: begin
          if (req && armed) begin
            state <= S_CONFIRM;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        S_CONFIRM: begin
          if (!req) begin
            state <= S_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt == CONFIRM_LAST) begin
            state          <= S_OPEN;
            cnt            <= '0;
            armed          <= 1'b0;
            hatch_open_cmd <= 1'b1;
          end else begin
            cnt <= cnt + TW'(1);
          end
        end
        S_OPEN: begin
          if (abort || cnt == OPEN_LAST) begin
            state          <= S_CLOSING;
            cnt            <= '0;
            hatch_open_cmd <= 1'b0;
          end else begin
            cnt <= cnt + TW'(1);
          end
        end
        S_CLOSING: begin
          // Closure wins over the timeout when both happen on the same cycle.
          if (hatch_closed) begin
            state <= S_COOLDOWN;
            cnt   <= '0;
            done  <= 1'b1;
          end else if (cnt == CLOSE_LAST) begin
            state <= S_FAULT;
            cnt   <= '0;
            fault <= 1'b1;
          end else begin
            cnt <= cnt + TW'(1);
          end
        end
        S_COOLDOWN: begin
          if (cnt == COOL_LAST) begin
            state <= S_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + TW'(1);
          end
        end
        S_FAULT: begin
          state <= S_FAULT;
        end
        default: begin
          state          <= S_IDLE;
          cnt            <= '0;
          hatch_open_cmd <= 1'b0;
          busy           <= 1'b0;
          fault          <= 1'b0;
        end
      endcase
    end
  end

`ifdef DROP_COUNTER_EN
  // Completed-drop counter: steps on the same edge that raises done, saturates at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count <= '0;
    end else if (state == S_CLOSING && hatch_closed && drop_count != {CNT_W{1'b1}}) begin
      drop_count <= drop_count + CNT_W'(1);
    end
  end
`else
  assign drop_count = '0;
`endif

endmodule
